multdiv_sequencer: RTL and testbench

- Issue/response controller between the pipeline and the shared multdiv unit.
- Accepts one mult or div request at a time and latches its operands and destination register.
- Issues a single-cycle ctrl_MULT/ctrl_DIV start pulse, then waits for data_resultRDY or a timeout.
- Holds the result, exception flag and destination tag until the pipeline consumes them, and asserts busy for stall logic.

---
 rtl/multdiv_sequencer.sv | 190 +++++++++++++++++++
 tb/tb_multdiv_sequencer.sv | 279 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/multdiv_sequencer.sv
`default_nettype none
// ============================================================================
// Module   : multdiv_sequencer
// Function : Issue/response controller between the pipeline and the shared
//            multdiv unit. Latches one mult/div request, fires a single-cycle
//            start pulse, waits for result-ready (or aborts on timeout) and
//            holds the response until the pipeline consumes it.
// Revision : 1.0  initial release
// ============================================================================
module multdiv_sequencer #(
  parameter int TIMEOUT = 40,  // max WAIT cycles before abort
  parameter int MIN_LAT = 2    // WAIT cycles during which resultRDY is ignored
) (
  input  logic        clock,
  input  logic        reset,
  // request side
  input  logic        req_valid,
  input  logic        req_op,
  input  logic [31:0] req_a,
  input  logic [31:0] req_b,
  input  logic [4:0]  req_rd,
  output logic        req_ready,
  // multdiv side
  output logic [31:0] md_operandA,
  output logic [31:0] md_operandB,
  output logic        md_ctrl_MULT,
  output logic        md_ctrl_DIV,
  output logic        md_reset,
  input  logic [31:0] md_result,
  input  logic        md_exception,
  input  logic        md_resultRDY,
  // response side
  output logic        resp_valid,
  output logic [31:0] resp_result,
  output logic        resp_exception,
  output logic [4:0]  resp_rd,
  input  logic        resp_ready,
  output logic        busy
);

  // Counter is one bit wider than needed for TIMEOUT so it can sit at
  // TIMEOUT in DONE without wrapping.
  localparam int c_CNT_W = $clog2(TIMEOUT) + 1;
  localparam logic [c_CNT_W-1:0] c_MIN_LAT  = c_CNT_W'(MIN_LAT);
  localparam logic [c_CNT_W-1:0] c_TMO_LAST = c_CNT_W'(TIMEOUT - 1);

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_START = 2'd1,
    S_WAIT  = 2'd2,
    S_DONE  = 2'd3
  } state_t;

  state_t               r_state;
  state_t               w_state_nxt;
  logic [c_CNT_W-1:0]   r_cnt;
  logic                 r_op;
  logic [31:0]          r_a;
  logic [31:0]          r_b;
  logic [4:0]           r_rd;
  logic [31:0]          r_result;
  logic                 r_exc;
  logic                 r_abort;
  logic                 w_accept;
  logic                 w_release;
  logic                 w_rdy_ok;
  logic                 w_timeout;

  // Completion qualifiers; a ready seen on the timeout cycle wins over abort.
  always_comb begin
    w_rdy_ok  = (r_state == S_WAIT) && (r_cnt >= c_MIN_LAT) && md_resultRDY;
    w_timeout = (r_state == S_WAIT) && !w_rdy_ok && (r_cnt == c_TMO_LAST);
  end

  // State register.
  always_ff @(posedge clock) begin
    if (reset) begin
      r_state <= S_IDLE;
    end else begin
      r_state <= w_state_nxt;
    end
  end

  // Next-state logic and state-decoded outputs.
  always_comb begin
    w_state_nxt  = r_state;
    w_accept     = 1'b0;
    w_release    = 1'b0;
    req_ready    = 1'b0;
    busy         = 1'b1;
    md_ctrl_MULT = 1'b0;
    md_ctrl_DIV  = 1'b0;
    resp_valid   = 1'b0;
    case (r_state)
      S_IDLE: begin
        req_ready = 1'b1;
        busy      = 1'b0;
        if (req_valid) begin
          w_accept    = 1'b1;
          w_state_nxt = S_START;
        end
      end
      S_START: begin
        md_ctrl_MULT = ~r_op;
        md_ctrl_DIV  = r_op;
        w_state_nxt  = S_WAIT;
      end
      S_WAIT: begin
        if (w_rdy_ok || w_timeout) begin
          w_state_nxt = S_DONE;
        end
      end
      S_DONE: begin
        resp_valid = 1'b1;
        if (resp_ready) begin
          w_release   = 1'b1;
          w_state_nxt = S_IDLE;
        end
      end
      default: begin
        w_state_nxt = S_IDLE;
      end
    endcase
  end

  // WAIT-cycle counter: cleared outside an operation, counts in WAIT,
  // holds its final value in DONE.
  always_ff @(posedge clock) begin
    if (reset) begin
      r_cnt <= '0;
    end else begin
      case (r_state)
        S_WAIT:  r_cnt <= r_cnt + 1'b1;
        S_DONE:  r_cnt <= r_cnt;
        default: r_cnt <= '0;
      endcase
    end
  end

  // Request latch; operands are registers so multdiv sees glitch-free
  // values from START through DONE, and zero once back in IDLE.
  always_ff @(posedge clock) begin
    if (reset) begin
      r_op <= 1'b0;
      r_a  <= '0;
      r_b  <= '0;
      r_rd <= '0;
    end else if (w_accept) begin
      r_op <= req_op;
      r_a  <= req_a;
      r_b  <= req_b;
      r_rd <= req_rd;
    end else if (w_release) begin
      r_a  <= '0;
      r_b  <= '0;
    end
  end

  // Response capture: real result on ready, zero plus exception on abort.
  always_ff @(posedge clock) begin
    if (reset) begin
      r_result <= '0;
      r_exc    <= 1'b0;
    end else if (w_rdy_ok) begin
      r_result <= md_result;
      r_exc    <= md_exception;
    end else if (w_timeout) begin
      r_result <= '0;
      r_exc    <= 1'b1;
    end
  end

  // One-cycle abort pulse, issued in the first DONE cycle after a timeout.
  always_ff @(posedge clock) begin
    if (reset) begin
      r_abort <= 1'b0;
    end else begin
      r_abort <= w_timeout;
    end
  end

  assign md_operandA    = r_a;
  assign md_operandB    = r_b;
  assign md_reset       = reset | r_abort;
  assign resp_result    = r_result;
  assign resp_exception = r_exc;
  assign resp_rd        = r_rd;

endmodule
`default_nettype wire

// File: tb/tb_multdiv_sequencer.sv
`default_nettype none
// ============================================================================
// Module   : tb_multdiv_sequencer
// Function : Self-checking bench for multdiv_sequencer with a behavioural
//            multdiv model and a response scoreboard.
// Revision : 1.0  initial release
// ============================================================================
module tb_multdiv_sequencer;

  logic        clk = 1'b0;
  logic        reset;
  logic        req_valid;
  logic        req_op;
  logic [31:0] req_a;
  logic [31:0] req_b;
  logic [4:0]  req_rd;
  logic        req_ready;
  logic [31:0] md_operandA;
  logic [31:0] md_operandB;
  logic        md_ctrl_MULT;
  logic        md_ctrl_DIV;
  logic        md_reset;
  logic [31:0] md_result;
  logic        md_exception;
  logic        md_resultRDY;
  logic        resp_valid;
  logic [31:0] resp_result;
  logic        resp_exception;
  logic [4:0]  resp_rd;
  logic        resp_ready;
  logic        busy;

  multdiv_sequencer #(.TIMEOUT(40), .MIN_LAT(2)) dut (
    .clock          (clk),
    .reset          (reset),
    .req_valid      (req_valid),
    .req_op         (req_op),
    .req_a          (req_a),
    .req_b          (req_b),
    .req_rd         (req_rd),
    .req_ready      (req_ready),
    .md_operandA    (md_operandA),
    .md_operandB    (md_operandB),
    .md_ctrl_MULT   (md_ctrl_MULT),
    .md_ctrl_DIV    (md_ctrl_DIV),
    .md_reset       (md_reset),
    .md_result      (md_result),
    .md_exception   (md_exception),
    .md_resultRDY   (md_resultRDY),
    .resp_valid     (resp_valid),
    .resp_result    (resp_result),
    .resp_exception (resp_exception),
    .resp_rd        (resp_rd),
    .resp_ready     (resp_ready),
    .busy           (busy)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [31:0] result;
    logic        exc;
    logic [4:0]  rd;
    int          lat;
  } exp_t;

  exp_t exp_q[$];
  int   acc_q[$];
  int   n_checks = 0;
  int   n_errors = 0;
  int   cyc = 0;
  int   n_mult = 0;
  int   n_div = 0;
  int   n_abort = 0;
  logic prev_valid = 1'b0;

  // multdiv model: ready at a chosen WAIT cycle, or held high (stale)
  int   wc = -1;
  int   rdy_at = 1000;
  logic mop = 1'b0;
  logic stale_hi = 1'b0;

  always @(posedge clk) cyc <= cyc + 1;

  // Model tracks WAIT cycles relative to the start pulse.
  always @(posedge clk) begin
    if (md_reset) wc <= -1;
    else if (md_ctrl_MULT) begin wc <= 0; mop <= 1'b0; end
    else if (md_ctrl_DIV) begin wc <= 0; mop <= 1'b1; end
    else if (wc >= 0 && wc < 100000) wc <= wc + 1;
  end

  assign md_resultRDY = stale_hi | (wc == rdy_at);
  assign md_result    = mop ? ((md_operandB == 32'd0) ? 32'd0 : md_operandA / md_operandB)
                            : md_operandA * md_operandB;
  assign md_exception = mop && (md_operandB == 32'd0);

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
    n_checks++;
    if (act !== req) begin
      n_errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, req);
    end
  endtask

  // Monitor: counts pulses, records accept cycles, scores responses.
  always @(negedge clk) begin
    if (reset) begin
      acc_q.delete();
      prev_valid = 1'b0;
    end else begin
      if (req_valid && req_ready) acc_q.push_back(cyc + 1);
      if (md_ctrl_MULT) n_mult++;
      if (md_ctrl_DIV) n_div++;
      if (md_reset) n_abort++;
      if (resp_valid && !prev_valid) begin
        check("resp_expected", 32'(exp_q.size() > 0), 32'd1);
        check("accept_seen", 32'(acc_q.size() > 0), 32'd1);
        if (exp_q.size() > 0 && acc_q.size() > 0) begin
          exp_t e;
          int   a;
          e = exp_q.pop_front();
          a = acc_q.pop_front();
          check("resp_result", resp_result, e.result);
          check("resp_exception", 32'(resp_exception), 32'(e.exc));
          check("resp_rd", 32'(resp_rd), 32'(e.rd));
          check("latency", 32'(cyc - a), 32'(e.lat));
        end
      end
      prev_valid = resp_valid;
    end
  end

  task automatic tick(input int n);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic issue(input logic op, input logic [31:0] a, input logic [31:0] b,
                       input logic [4:0] rd, input logic expect_resp,
                       input logic [31:0] er, input logic ee, input int el);
    int n;
    if (expect_resp) exp_q.push_back('{er, ee, rd, el});
    req_op = op; req_a = a; req_b = b; req_rd = rd; req_valid = 1'b1;
    n = 0;
    while (!req_ready && n < 300) begin
      tick(1);
      n++;
    end
    check("accept_bound", 32'(req_ready), 32'd1);
    if (req_ready) tick(1);
    req_valid = 1'b0;
  endtask

  task automatic wait_resp(input int stall);
    int          n;
    int          busy_low;
    int          changed;
    logic [31:0] s_res;
    logic        s_exc;
    logic [4:0]  s_rd;
    n = 0; busy_low = 0; changed = 0;
    while (!resp_valid && n < 200) begin
      if (!busy) busy_low++;
      tick(1);
      n++;
    end
    check("resp_bound", 32'(resp_valid), 32'd1);
    check("busy_while_active", 32'(busy_low), 32'd0);
    s_res = resp_result; s_exc = resp_exception; s_rd = resp_rd;
    repeat (stall) begin
      tick(1);
      if (!resp_valid || resp_result !== s_res || resp_exception !== s_exc || resp_rd !== s_rd)
        changed++;
    end
    if (stall > 0) check("resp_stable_in_stall", 32'(changed), 32'd0);
    resp_ready = 1'b1;
    tick(1);
    resp_ready = 1'b0;
    check("idle_after_consume", 32'(req_ready), 32'd1);
    check("valid_drop", 32'(resp_valid), 32'd0);
  endtask

  // Watchdog: the run must never hang.
  initial begin
    #1000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  // Directed stimulus.
  initial begin
    int m0, d0, a0;
    reset = 1'b1; req_valid = 1'b0; req_op = 1'b0; req_a = '0; req_b = '0;
    req_rd = '0; resp_ready = 1'b0;
    tick(3);
    check("md_reset_in_reset", 32'(md_reset), 32'd1);
    reset = 1'b0;
    #1;
    check("rst_req_ready", 32'(req_ready), 32'd1);
    check("rst_busy", 32'(busy), 32'd0);
    check("rst_resp_valid", 32'(resp_valid), 32'd0);
    check("rst_operandA", md_operandA, 32'd0);
    check("rst_operandB", md_operandB, 32'd0);
    check("rst_ctrl", 32'({md_ctrl_MULT, md_ctrl_DIV}), 32'd0);
    check("rst_md_reset_low", 32'(md_reset), 32'd0);
    tick(1);

    // multiply 6*7, ready at WAIT cycle 17
    m0 = n_mult; d0 = n_div; rdy_at = 17;
    issue(1'b0, 32'd6, 32'd7, 5'd5, 1'b1, 32'd42, 1'b0, 19);
    check("mul_operandA", md_operandA, 32'd6);
    wait_resp(0);
    check("mul_pulses", 32'(n_mult - m0), 32'd1);
    check("mul_no_div", 32'(n_div - d0), 32'd0);
    check("idle_operandA", md_operandA, 32'd0);

    // divide by zero, ready at WAIT cycle 33
    m0 = n_mult; d0 = n_div; rdy_at = 33;
    issue(1'b1, 32'd100, 32'd0, 5'd9, 1'b1, 32'd0, 1'b1, 35);
    wait_resp(0);
    check("div_pulses", 32'(n_div - d0), 32'd1);
    check("div_no_mul", 32'(n_mult - m0), 32'd0);

    // stale ready held high; accepted at counter 2; 5-cycle backpressure
    stale_hi = 1'b1; rdy_at = 1000;
    issue(1'b0, 32'h1234, 32'd2, 5'd3, 1'b1, 32'h2468, 1'b0, 4);
    wait_resp(5);
    stale_hi = 1'b0;

    // timeout: ready never comes, model result must not be captured
    a0 = n_abort; rdy_at = 1000;
    issue(1'b1, 32'd50, 32'd5, 5'd7, 1'b1, 32'd0, 1'b1, 41);
    wait_resp(0);
    check("abort_pulse_width", 32'(n_abort - a0), 32'd1);

    // ready on the last WAIT cycle wins over timeout
    a0 = n_abort; rdy_at = 39;
    issue(1'b1, 32'd50, 32'd5, 5'd8, 1'b1, 32'd10, 1'b0, 41);
    wait_resp(0);
    check("rdy_wins_no_abort", 32'(n_abort - a0), 32'd0);

    // reset at WAIT cycle 10
    rdy_at = 17;
    issue(1'b0, 32'd9, 32'd9, 5'd1, 1'b0, 32'd0, 1'b0, 0);
    tick(11);
    reset = 1'b1;
    tick(1);
    reset = 1'b0;
    #1;
    check("mid_rst_req_ready", 32'(req_ready), 32'd1);
    check("mid_rst_busy", 32'(busy), 32'd0);
    check("mid_rst_resp_valid", 32'(resp_valid), 32'd0);
    check("mid_rst_operands", md_operandA | md_operandB, 32'd0);
    tick(1);
    issue(1'b0, 32'd3, 32'd4, 5'd2, 1'b1, 32'd12, 1'b0, 19);
    wait_resp(0);

    // back-to-back: second request held while busy
    m0 = n_mult; d0 = n_div; rdy_at = 5;
    issue(1'b0, 32'd5, 32'd5, 5'd10, 1'b1, 32'd25, 1'b0, 7);
    fork
      issue(1'b1, 32'd81, 32'd9, 5'd11, 1'b1, 32'd9, 1'b0, 7);
      wait_resp(2);
    join
    wait_resp(0);
    check("b2b_mul_pulses", 32'(n_mult - m0), 32'd1);
    check("b2b_div_pulses", 32'(n_div - d0), 32'd1);

    tick(3);
    check("scoreboard_drained", 32'(exp_q.size()), 32'd0);
    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule
`default_nettype wire
